// File: rtl/zrec_pkg.sv
// Shared definitions for the z-stream 1101 recognizer: state encoding and pattern constants.
package zrec_pkg;

    localparam logic [1:0] ST_S0   = 2'd0;
    localparam logic [1:0] ST_S1   = 2'd1;
    localparam logic [1:0] ST_S11  = 2'd2;
    localparam logic [1:0] ST_S110 = 2'd3;

    localparam int unsigned PAT_LEN = 4;

    // Each state names the longest suffix of accepted samples that is a prefix of 1101.
    typedef enum logic [1:0] {
        S0   = ST_S0,
        S1   = ST_S1,
        S11  = ST_S11,
        S110 = ST_S110
    } state_t;

    // True when accepting bit b in state s completes the pattern.
    function automatic logic completes_match(input state_t s, input logic b);
        return (s == S110) && b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    // Count increments, holding at the all-ones ceiling; reset and clear both zero it.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/z_sequence_recognizer.sv
// Recognizes the serial pattern 1,1,0,1 (overlapping) on valid z samples, pulses hit and counts matches.
module z_sequence_recognizer
    import zrec_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               z_valid,
    input  logic               z,
    input  logic               clear,
    output logic               hit,
    output logic [COUNT_W-1:0] hit_count,
    output logic               busy
);

    state_t state;
    state_t next_state;
    logic   match;

    // Next-state and match detection; z is only looked at when it is marked valid.
    always_comb begin
        next_state = state;
        match      = 1'b0;
        if (z_valid) begin
            match = completes_match(state, z);
            case (state)
                S0:      next_state = z ? S1  : S0;
                S1:      next_state = z ? S11 : S0;
                S11:     next_state = z ? S11 : S110;
                S110:    next_state = z ? S1  : S0;
                default: next_state = S0;
            endcase
        end
    end

    // State and hit registers; reset and clear discard any partial match and the current sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= S0;
            hit   <= 1'b0;
        end else begin
            state <= next_state;
            hit   <= match;
        end
    end

    assign busy = (state != S0);

    sat_counter #(
        .W(COUNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (match),
        .count (hit_count)
    );

endmodule

// File: tb/tb_z_sequence_recognizer.sv
// Self-checking bench for z_sequence_recognizer: directed scenarios plus randomized traffic vs. a sample-history model.
module tb_z_sequence_recognizer;

    logic       clk;
    logic       reset;
    logic       z_valid;
    logic       z;
    logic       clear;
    logic       hit;
    logic [7:0] hit_count;
    logic       busy;
    logic       hit_s;
    logic [1:0] hit_count_s;
    logic       busy_s;

    int errors;
    int checks;

    // Reference state: window of the last four accepted samples and how many were accepted since reset/clear.
    logic [3:0] hist;
    int         n_acc;
    int         cnt8;
    int         cnt2;
    logic       exp_hit;
    logic       exp_busy;

    z_sequence_recognizer #(.COUNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .z_valid   (z_valid),
        .z         (z),
        .clear     (clear),
        .hit       (hit),
        .hit_count (hit_count),
        .busy      (busy)
    );

    z_sequence_recognizer #(.COUNT_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .z_valid   (z_valid),
        .z         (z),
        .clear     (clear),
        .hit       (hit_s),
        .hit_count (hit_count_s),
        .busy      (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare all outputs.
    task automatic step(input logic r, input logic c, input logic v, input logic b);
        reset   = r;
        clear   = c;
        z_valid = v;
        z       = b;
        @(posedge clk);
        if (r || c) begin
            hist    = 4'b0000;
            n_acc   = 0;
            cnt8    = 0;
            cnt2    = 0;
            exp_hit = 1'b0;
        end else if (v) begin
            hist    = {hist[2:0], b};
            n_acc++;
            exp_hit = (n_acc >= 4) && (hist == 4'b1101);
            if (exp_hit) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3)   cnt2++;
            end
        end else begin
            exp_hit = 1'b0;
        end
        exp_busy = ((n_acc >= 1) && hist[0]) || ((n_acc >= 3) && (hist[2:0] == 3'b110));
        #1;
        check_val("hit",         32'(hit),         32'(exp_hit));
        check_val("hit_count",   32'(hit_count),   32'(cnt8));
        check_val("busy",        32'(busy),        32'(exp_busy));
        check_val("hit_sat",     32'(hit_s),       32'(exp_hit));
        check_val("hit_count_w2", 32'(hit_count_s), 32'(cnt2));
    endtask

    task automatic send_bits(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b0, 1'b1, bits[i]);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        hist    = 4'b0000;
        n_acc   = 0;
        cnt8    = 0;
        cnt2    = 0;
        reset   = 1'b1;
        clear   = 1'b0;
        z_valid = 1'b0;
        z       = 1'b0;

        // Reset then idle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Basic match; hit visible right after the 4th sample, FSM left in S1
        send_bits(4'b1101);
        check_val("basic_hit",  32'(hit),       32'd1);
        check_val("basic_cnt",  32'(hit_count), 32'd1);
        check_val("basic_busy", 32'(busy),      32'd1);

        // Overlap: 1101101 yields two hits
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(4'b1101);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("overlap_cnt", 32'(hit_count), 32'd2);

        // Gaps between valid samples
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("gap_cnt", 32'(hit_count), 32'd1);

        // Clear mid-match discards the partial match and the sample presented with it
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_val("clear_hit",  32'(hit),       32'd0);
        check_val("clear_cnt",  32'(hit_count), 32'd0);
        check_val("clear_busy", 32'(busy),      32'd0);
        send_bits(4'b1101);
        check_val("post_clear_cnt", 32'(hit_count), 32'd1);

        // Saturation of the 2-bit counter over five matches, then reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 5; m++) send_bits(4'b1101);
        check_val("sat_cnt_w2", 32'(hit_count_s), 32'd3);
        check_val("sat_cnt_w8", 32'(hit_count),   32'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("sat_reset", 32'(hit_count_s), 32'd0);

        // Randomized traffic, biased toward 1s so matches are frequent
        for (int i = 0; i < 3000; i++) begin
            logic r, c, v, b;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 9) < 6);
            step(r, c, v, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
